// File: rtl/posit_pkg.sv
// Posit FPU shared types: formats, FMA operations, status flags and helpers.
// Pure declarations, no logic or state.
// Ports: none (package).
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16_ES1 = 2'd0,
        POSIT8_ES0  = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    localparam int unsigned POSIT_MAXW = 32;

    typedef enum logic [2:0] {
        FMADD  = 3'd0,
        FNMSUB = 3'd1,
        ADD    = 3'd2,
        MUL    = 3'd3,
        DIV    = 3'd4,
        SQRT   = 3'd5,
        CMP    = 3'd6,
        CVT    = 3'd7
    } operation_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned posit_width(posit_format_e fmt);
        case (fmt)
            POSIT8_ES0:  return 8;
            POSIT32_ES2: return 32;
            default:     return 16;
        endcase
    endfunction

    // NaR: sign bit set, all other bits zero. Callers cast down to their width.
    function automatic logic [POSIT_MAXW-1:0] nar_pattern(int unsigned n);
        return POSIT_MAXW'(1) << (n - 1);
    endfunction

    // Operations the FMA datapath can execute; anything else is answered locally.
    function automatic logic is_fma_op(operation_e op);
        return op inside {FMADD, FNMSUB, ADD, MUL};
    endfunction

endpackage

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: combinational grant; pointer moves to winner+1 on the next edge.
// Backpressure: en_i=0 suppresses the grant and freezes the pointer.
// Ports: clk_i/rst_ni, req_i (request vector), en_i (grant allowed),
//        gnt_o (one-hot or zero), gnt_id_o (winner index), gnt_vld_o (grant issued).
module posit_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    // One spare bit so ptr + offset never wraps before the modulo correction.
    localparam int unsigned IW = IDW + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IW-1:0]  idx;
    logic           found;
    logic [IDW-1:0] win;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + IW'(k);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (!found && req_i[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    assign gnt_vld_o = found && en_i;
    assign gnt_id_o  = win;
    assign gnt_o     = gnt_vld_o ? (NREQ'(1) << win) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/posit_fma_sched.sv
// Shares one pipelined posit FMA among NREQ requesters with round-robin issue.
// Latency: request to rsp_valid_o is LAT+1 cycles when the response side keeps up.
// Backpressure: credits (in flight + buffered) cap at DEPTH; req_ready_o drops until a pop.
// Ports: req_* (per-requester valid/ready, operands {c,b,a}, op, mod),
//        fma_* (issue to / results from the FMA, plus flush), rsp_* (valid/ready
//        response with requester id), flush_i (kill all work), busy_o (credits held).
module posit_fma_sched
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0),
    parameter int unsigned   NREQ    = 4,
    parameter int unsigned   LAT     = 3,
    parameter int unsigned   DEPTH   = 4,
    parameter int unsigned   IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned  N       = posit_width(pFormat),
    localparam int unsigned  OPW     = $bits(operation_e),
    localparam int unsigned  SW      = $bits(status_t)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*3*N-1:0]   req_operands_i,
    input  logic [NREQ*OPW-1:0]   req_op_i,
    input  logic [NREQ-1:0]       req_op_mod_i,
    output logic                  fma_valid_o,
    output logic [3*N-1:0]        fma_operands_o,
    output logic [OPW-1:0]        fma_op_o,
    output logic                  fma_op_mod_o,
    output logic                  fma_flush_o,
    input  logic                  fma_valid_i,
    input  logic [N-1:0]          fma_result_i,
    input  logic [SW-1:0]         fma_status_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [N-1:0]          rsp_result_o,
    output logic [SW-1:0]         rsp_status_o,
    output logic                  busy_o
);

    localparam int unsigned   CW  = $clog2(DEPTH + 1);
    localparam int unsigned   PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [N-1:0]  NAR = N'(nar_pattern(N));

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   result;
        status_t        status;
    } entry_t;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits and response FIFO state
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    entry_t         mem_q [DEPTH];

    // Latency-matched tag pipe
    logic [LAT-1:0] pipe_vld_q;
    logic [LAT-1:0] pipe_ill_q;
    logic [IDW-1:0] pipe_id_q [LAT];

    logic           pop, push, issue_ok, gnt_vld, legal;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    operation_e     win_op;
    entry_t         push_entry;
    entry_t         head;

    assign rsp_valid_o = (occ_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;

    // A pop in the same cycle frees the credit this issue would need.
    // Gated by rst_ni so nothing is granted while reset is held.
    assign issue_ok = rst_ni && !flush_i &&
                      ((cnt_q < CW'(DEPTH)) || ((cnt_q == CW'(DEPTH)) && pop));

    posit_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .en_i      (issue_ok),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready_o = gnt;
    assign win_op      = operation_e'(req_op_i[gnt_id*OPW +: OPW]);
    assign legal       = is_fma_op(win_op);

    // Illegal ops consume a grant and a credit but never reach the FMA.
    assign fma_valid_o    = gnt_vld && legal;
    assign fma_operands_o = fma_valid_o ? req_operands_i[gnt_id*3*N +: 3*N] : '0;
    assign fma_op_o       = fma_valid_o ? win_op : '0;
    assign fma_op_mod_o   = fma_valid_o ? req_op_mod_i[gnt_id] : 1'b0;
    assign fma_flush_o    = flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            pipe_ill_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else if (flush_i) begin
            pipe_vld_q <= '0;
            pipe_ill_q <= '0;
        end else begin
            pipe_vld_q[0] <= gnt_vld;
            pipe_ill_q[0] <= gnt_vld && !legal;
            pipe_id_q[0]  <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_ill_q[i] <= pipe_ill_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    // The tail of the tag pipe decides the push; fma_valid_i alone never does,
    // so a stray result with no matching tag is discarded.
    assign push = pipe_vld_q[LAT-1] && !flush_i;

    always_comb begin
        push_entry        = '0;
        push_entry.id     = pipe_id_q[LAT-1];
        if (pipe_ill_q[LAT-1]) begin
            push_entry.result    = NAR;
            push_entry.status.NV = 1'b1;
        end else begin
            push_entry.result = fma_result_i;
            push_entry.status = status_t'(fma_status_i);
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            cnt_d    = '0;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(gnt_vld) - CW'(pop);
            occ_d = occ_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through occ_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign rsp_id_o     = rsp_valid_o ? head.id : '0;
    assign rsp_result_o = rsp_valid_o ? head.result : '0;
    assign rsp_status_o = rsp_valid_o ? head.status : '0;
    assign busy_o       = (cnt_q != '0);

    // FMA results must line up exactly with legal tags leaving the pipe.
    a_result_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        fma_valid_i == (pipe_vld_q[LAT-1] && !pipe_ill_q[LAT-1]));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (push && !pop) |-> (occ_q != CW'(DEPTH)));

endmodule

// File: tb/tb_posit_fma_sched.sv
module tb_posit_fma_sched;
    import posit_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT = 3;
    localparam int DEPTH = 4;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*3*N-1:0] req_operands = '0;
    logic [NREQ*3-1:0] req_op = '0;
    logic [NREQ-1:0] req_op_mod = '0;
    logic fma_valid_o_s;
    logic [3*N-1:0] fma_operands;
    logic [2:0] fma_op;
    logic fma_op_mod;
    logic fma_flush;
    logic fma_valid_i_s = 1'b0;
    logic [N-1:0] fma_result = '0;
    logic [4:0] fma_status = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [1:0] rsp_id;
    logic [N-1:0] rsp_result;
    logic [4:0] rsp_status;
    logic busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    posit_fma_sched #(
        .pFormat (POSIT16_ES1),
        .NREQ    (NREQ),
        .LAT     (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_operands_i (req_operands),
        .req_op_i       (req_op),
        .req_op_mod_i   (req_op_mod),
        .fma_valid_o    (fma_valid_o_s),
        .fma_operands_o (fma_operands),
        .fma_op_o       (fma_op),
        .fma_op_mod_o   (fma_op_mod),
        .fma_flush_o    (fma_flush),
        .fma_valid_i    (fma_valid_i_s),
        .fma_result_i   (fma_result),
        .fma_status_i   (fma_status),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_result_o   (rsp_result),
        .rsp_status_o   (rsp_status),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Small-integer posit16/es1 values used by the vectors.
    function automatic int p2i(logic [15:0] p);
        case (p)
            16'h0000: return 0;
            16'h4000: return 1;
            16'h5000: return 2;
            16'h5800: return 3;
            16'h6000: return 4;
            default:  return 99;
        endcase
    endfunction

    function automatic logic [15:0] i2p(int v);
        case (v)
            0: return 16'h0000;
            1: return 16'h4000;
            2: return 16'h5000;
            3: return 16'h5800;
            4: return 16'h6000;
            default: return 16'h7fff;
        endcase
    endfunction

    function automatic logic [15:0] fmath(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic [15:0] c);
        case (op)
            3'd0: return i2p(p2i(a) * p2i(b) + p2i(c));
            3'd1: return i2p(p2i(c) - p2i(a) * p2i(b));
            3'd2: return i2p(p2i(a) + p2i(b));
            default: return i2p(p2i(a) * p2i(b));
        endcase
    endfunction

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [4:0]  st;
        int          avail;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] res;
    } fma_t;

    exp_t m_q[$];
    fma_t f_q[$];
    int m_ptr = 0;
    int m_cnt = 0;

    // Reference model + FMA stand-in, evaluated mid-cycle when inputs are stable.
    always @(negedge clk) begin
        logic erv, pop, allowed, found, legal, grant;
        int w;
        logic [3:0] egnt;
        logic [2:0] eop;
        logic [47:0] eops;
        exp_t e;
        fma_t f;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_fma_valid", fma_valid_o_s, 0);
            chk("rst_fma_operands", fma_operands, 0);
            chk("rst_fma_flush", fma_flush, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_busy", busy, 0);
            m_q.delete();
            f_q.delete();
            m_ptr = 0;
            m_cnt = 0;
            fma_valid_i_s = 1'b0;
            fma_result = '0;
            fma_status = '0;
        end else begin
            erv = (m_q.size() > 0) && (m_q[0].avail <= cyc);
            pop = erv && rsp_ready;
            allowed = !flush && ((m_cnt < DEPTH) || ((m_cnt == DEPTH) && pop));
            found = 1'b0;
            w = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % NREQ;
                end
            end
            grant = allowed && found;
            eop = req_op[w*3 +: 3];
            eops = req_operands[w*48 +: 48];
            legal = eop inside {FMADD, FNMSUB, ADD, MUL};
            egnt = grant ? (4'(1) << w) : 4'd0;
            chk("req_ready", req_ready, egnt);
            chk("fma_valid", fma_valid_o_s, grant && legal);
            chk("fma_operands", fma_operands, (grant && legal) ? eops : 48'd0);
            chk("fma_op", fma_op, (grant && legal) ? eop : 3'd0);
            chk("fma_op_mod", fma_op_mod, grant && legal && req_op_mod[w]);
            chk("fma_flush", fma_flush, flush);
            chk("busy", busy, m_cnt != 0);
            chk("rsp_valid", rsp_valid, erv);
            if (erv) begin
                chk("rsp_id", rsp_id, m_q[0].id);
                chk("rsp_result", rsp_result, m_q[0].res);
                chk("rsp_status", rsp_status, m_q[0].st);
            end
            // FMA stand-in drives the result due this cycle (dropped by the DUT if flushing).
            if (f_q.size() > 0 && f_q[0].due == cyc) begin
                fma_valid_i_s = 1'b1;
                fma_result = f_q[0].res;
                fma_status = '0;
                f_q.delete(0);
            end else begin
                fma_valid_i_s = 1'b0;
                fma_result = '0;
                fma_status = '0;
            end
            if (flush) begin
                m_q.delete();
                f_q.delete();
                m_cnt = 0;
            end else begin
                if (pop) m_q.delete(0);
                if (grant) begin
                    m_ptr = (w + 1) % NREQ;
                    e.id = w;
                    e.res = legal ? fmath(eop, eops[15:0], eops[31:16], eops[47:32]) : 16'h8000;
                    e.st = legal ? 5'b00000 : 5'b10000;
                    e.avail = cyc + LAT + 1;
                    m_q.push_back(e);
                    if (legal) begin
                        f.due = cyc + LAT;
                        f.res = e.res;
                        f_q.push_back(f);
                    end
                end
                m_cnt = m_cnt + int'(grant) - int'(pop);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c, input logic md);
        req_valid[r] = 1'b1;
        req_op[r*3 +: 3] = op;
        req_operands[r*48 +: 48] = {c, b, a};
        req_op_mod[r] = md;
    endtask

    task automatic clr_reqs();
        req_valid = '0;
        req_op = '0;
        req_operands = '0;
        req_op_mod = '0;
    endtask

    initial begin
        int ng;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single FMADD from requester 2: 1*2+1 = 3
        tick();
        set_req(2, FMADD, 16'h4000, 16'h5000, 16'h4000, 1'b1);
        @(negedge clk);
        chk("t1_issue", fma_valid_o_s, 1);
        chk("t1_grant", req_ready, 4'b0100);
        chk("t1_operands", fma_operands, {16'h4000, 16'h5000, 16'h4000});
        tick();
        clr_reqs();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t1_rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_result", rsp_result, 16'h5800);
        chk("t1_rsp_status", rsp_status, 0);
        repeat (3) tick();

        // All requesters stream MUL 2*2; pointer starts at 3 after the previous grant to 2
        for (int r = 0; r < NREQ; r++) set_req(r, MUL, 16'h5000, 16'h5000, 16'h0000, r[0]);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t2_grant", req_ready, 4'(1) << ((3 + k) % 4));
            if (k >= 4) begin
                chk("t2_rsp_result", rsp_result, 16'h6000);
                chk("t2_rsp_id", rsp_id, (3 + k - 4) % 4);
            end
            tick();
        end
        clr_reqs();
        repeat (8) tick();

        // Credit limit with a stalled response port
        rsp_ready = 1'b0;
        set_req(0, FMADD, 16'h4000, 16'h4000, 16'h4000, 1'b0);
        ng = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready[0]) ng++;
            tick();
        end
        chk("t3_grant_count", ng, 4);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_pop_regrant", req_ready, 4'b0001);
        chk("t3_head_result", rsp_result, 16'h5000);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t3_hold", req_ready, 0);
        tick();
        clr_reqs();
        rsp_ready = 1'b1;
        repeat (10) tick();

        // Illegal op sandwiched between two legal ops from requester 1
        set_req(1, MUL, 16'h5000, 16'h5000, 16'h0000, 1'b1);
        @(negedge clk);
        chk("t4_first_issue", fma_valid_o_s, 1);
        tick();
        set_req(1, DIV, 16'h5000, 16'h4000, 16'h0000, 1'b1);
        @(negedge clk);
        chk("t4_illegal_nofma", fma_valid_o_s, 0);
        chk("t4_illegal_grant", req_ready, 4'b0010);
        tick();
        set_req(1, FMADD, 16'h4000, 16'h5000, 16'h4000, 1'b1);
        @(negedge clk);
        tick();
        clr_reqs();
        @(negedge clk);
        @(negedge clk);
        chk("t4_rsp1", rsp_result, 16'h6000);
        @(negedge clk);
        chk("t4_rsp2_result", rsp_result, 16'h8000);
        chk("t4_rsp2_status", rsp_status, 5'b10000);
        chk("t4_rsp2_id", rsp_id, 1);
        @(negedge clk);
        chk("t4_rsp3", rsp_result, 16'h5800);
        repeat (4) tick();

        // Flush with 2 buffered + 2 in flight
        rsp_ready = 1'b0;
        set_req(0, MUL, 16'h5000, 16'h5000, 16'h0000, 1'b0);
        repeat (5) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("t5_fma_flush", fma_flush, 1);
        chk("t5_no_grant", req_ready, 0);
        chk("t5_busy_before", busy, 1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_rsp_cleared", rsp_valid, 0);
        chk("t5_busy_cleared", busy, 0);
        chk("t5_regrant", req_ready, 4'b0001);
        tick();
        clr_reqs();
        rsp_ready = 1'b1;
        repeat (8) tick();

        // Reset with ops in flight
        set_req(0, MUL, 16'h5000, 16'h5000, 16'h0000, 1'b0);
        set_req(3, MUL, 16'h5000, 16'h4000, 16'h0000, 1'b0);
        repeat (2) tick();
        rst_n = 1'b0;
        clr_reqs();
        set_req(1, MUL, 16'h4000, 16'h4000, 16'h0000, 1'b0);
        set_req(3, MUL, 16'h4000, 16'h4000, 16'h0000, 1'b0);
        @(negedge clk);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_fma_valid", fma_valid_o_s, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", req_ready, 4'b0010);
        tick();
        clr_reqs();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
